// File: rtl/sk6812_rx_pkg.sv
// Shared definitions for the SK6812 receive path: FSM states, default
// pulse-timing constants (50 MHz clock) and counter widths.
package sk6812_rx_pkg;

    typedef enum logic [2:0] {
        ST_SYNC = 3'd0,
        ST_IDLE = 3'd1,
        ST_HIGH = 3'd2,
        ST_LOW  = 3'd3,
        ST_DONE = 3'd4
    } rx_state_t;

    localparam int unsigned RX_ADDR_W     = 6;
    localparam int unsigned RX_MIN_HIGH   = 5;
    localparam int unsigned RX_BIT_THRESH = 23;
    localparam int unsigned RX_MAX_HIGH   = 75;
    localparam int unsigned RX_RESET_CYC  = 2500;

    localparam int unsigned HCNT_W  = 7;
    localparam int unsigned LCNT_W  = 12;
    localparam int unsigned NBITS_W = 11;
    localparam int unsigned WORD_W  = 32;

    // Left-justify the first nbits shifted-in bits of a partial word; LSBs become 0.
    function automatic logic [WORD_W-1:0] left_justify(input logic [WORD_W-1:0] sr,
                                                       input logic [4:0]        nbits);
        logic [5:0] sh;
        sh = 6'd32 - {1'b0, nbits};
        return sr << sh;
    endfunction

endpackage

// File: rtl/sk6812_rx_ram.sv
// Word buffer for the SK6812 receiver: one write port, one registered read port.
module sk6812_rx_ram
    import sk6812_rx_pkg::*;
#(
    parameter int unsigned ADDR_W = RX_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wa,
    input  logic [WORD_W-1:0] i_wd,
    input  logic [ADDR_W-1:0] i_ra,
    output logic [WORD_W-1:0] o_rd
);

    logic [WORD_W-1:0] r_mem [0:(2**ADDR_W)-1];
    logic [WORD_W-1:0] r_rd;

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    // Registered read, cleared by reset so the output reads 0 out of reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd <= '0;
        end else begin
            r_rd <= r_mem[i_ra];
        end
    end

    assign o_rd = r_rd;

endmodule

// File: rtl/sk6812_rx.sv
// SK6812 NRZ receiver: synchronizes din, measures high/low widths, classifies
// bits, packs them MSB-first into 32-bit words and stores them in a local buffer.
module sk6812_rx
    import sk6812_rx_pkg::*;
#(
    parameter int unsigned ram_addwidth = RX_ADDR_W,
    parameter int unsigned MIN_HIGH     = RX_MIN_HIGH,
    parameter int unsigned BIT_THRESH   = RX_BIT_THRESH,
    parameter int unsigned MAX_HIGH     = RX_MAX_HIGH,
    parameter int unsigned RESET_CYC    = RX_RESET_CYC
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    din,
    input  logic                    enable,
    input  logic                    clr,
    input  logic [ram_addwidth-1:0] rd_add,
    output logic [WORD_W-1:0]       rd,
    output logic [ram_addwidth:0]   n_words,
    output logic [NBITS_W-1:0]      n_bits,
    output logic                    frame_done,
    output logic                    busy,
    output logic [2:0]              err
);

    localparam int unsigned DEPTH = 2**ram_addwidth;

    localparam logic [ram_addwidth:0] P_DEPTH  = (ram_addwidth+1)'(DEPTH);
    localparam logic [ram_addwidth:0] NW_ONE   = (ram_addwidth+1)'(1);
    localparam logic [HCNT_W-1:0]     P_MIN    = HCNT_W'(MIN_HIGH);
    localparam logic [HCNT_W-1:0]     P_THR    = HCNT_W'(BIT_THRESH);
    localparam logic [HCNT_W-1:0]     P_MAX    = HCNT_W'(MAX_HIGH);
    localparam logic [HCNT_W-1:0]     HCNT_ONE = HCNT_W'(1);
    localparam logic [LCNT_W-1:0]     P_GAP    = LCNT_W'(RESET_CYC);
    localparam logic [LCNT_W-1:0]     P_GAP_M1 = LCNT_W'(RESET_CYC - 1);
    localparam logic [LCNT_W-1:0]     LCNT_ONE = LCNT_W'(1);
    localparam logic [NBITS_W-1:0]    NB_ONE   = NBITS_W'(1);

    rx_state_t r_state, w_state_next;

    logic                    r_din_s1, r_din_s2, r_din_d;
    logic [HCNT_W-1:0]       r_hcnt;
    logic [LCNT_W-1:0]       r_lcnt;
    logic [WORD_W-1:0]       r_sr;
    logic [4:0]              r_biw;
    logic                    r_store_pend;
    logic [ram_addwidth:0]   r_n_words;
    logic [NBITS_W-1:0]      r_n_bits;
    logic [2:0]              r_err;

    logic                    w_rise, w_fall;
    logic                    w_start, w_long, w_bit_ok, w_bit_val, w_flush;
    logic                    w_we_req, w_has_room, w_ram_we;
    logic [WORD_W-1:0]       w_wdata;
    logic [HCNT_W-1:0]       w_hcnt_inc;
    logic [LCNT_W-1:0]       w_lcnt_inc;

    // Two-flop synchronizer plus one delay stage for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_din_s1 <= 1'b0;
            r_din_s2 <= 1'b0;
            r_din_d  <= 1'b0;
        end else begin
            r_din_s1 <= din;
            r_din_s2 <= r_din_s1;
            r_din_d  <= r_din_s2;
        end
    end

    assign w_rise     = r_din_s2 & ~r_din_d;
    assign w_fall     = ~r_din_s2 & r_din_d;
    assign w_hcnt_inc = (r_hcnt == '1) ? r_hcnt : r_hcnt + HCNT_ONE;
    assign w_lcnt_inc = (r_lcnt == '1) ? r_lcnt : r_lcnt + LCNT_ONE;

    // State register; clr and enable=0 both force resynchronization.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_SYNC;
        end else if (clr || !enable) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-state strobes for the datapath.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_long       = 1'b0;
        w_bit_ok     = 1'b0;
        w_bit_val    = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            ST_SYNC: begin
                if (!r_din_s2 && (r_lcnt >= P_GAP_M1)) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (w_rise) begin
                    w_start      = 1'b1;
                    w_state_next = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (r_hcnt > P_MAX) begin
                    w_long       = 1'b1;
                    w_state_next = ST_SYNC;
                end else if (w_fall) begin
                    w_state_next = ST_LOW;
                    w_bit_ok     = (r_hcnt >= P_MIN);
                    w_bit_val    = (r_hcnt >= P_THR);
                end
            end
            ST_LOW: begin
                if (w_rise) begin
                    w_state_next = ST_HIGH;
                end else if (r_lcnt >= P_GAP) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
                w_flush      = (r_biw != '0);
            end
            default: begin
                w_state_next = ST_SYNC;
            end
        endcase
    end

    // A full word is written the cycle after its 32nd bit; a partial word at DONE.
    assign w_we_req   = enable && !clr && (r_store_pend || w_flush);
    assign w_has_room = (r_n_words < P_DEPTH);
    assign w_ram_we   = w_we_req && w_has_room;
    assign w_wdata    = r_store_pend ? r_sr : left_justify(r_sr, r_biw);

    // Counters, shift register, word/bit counts and sticky error flags.
    // lcnt also runs while HIGH so a discarded glitch does not restart gap timing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hcnt       <= '0;
            r_lcnt       <= '0;
            r_sr         <= '0;
            r_biw        <= '0;
            r_store_pend <= 1'b0;
            r_n_words    <= '0;
            r_n_bits     <= '0;
            r_err        <= '0;
        end else if (clr) begin
            r_hcnt       <= '0;
            r_lcnt       <= '0;
            r_sr         <= '0;
            r_biw        <= '0;
            r_store_pend <= 1'b0;
            r_n_words    <= '0;
            r_n_bits     <= '0;
            r_err        <= '0;
        end else if (!enable) begin
            r_hcnt       <= '0;
            r_lcnt       <= '0;
            r_store_pend <= 1'b0;
        end else begin
            r_store_pend <= 1'b0;
            case (r_state)
                ST_SYNC: begin
                    if (r_din_s2 || (w_state_next == ST_IDLE)) begin
                        r_lcnt <= '0;
                    end else begin
                        r_lcnt <= w_lcnt_inc;
                    end
                end
                ST_IDLE: begin
                    if (w_start) begin
                        r_hcnt    <= HCNT_ONE;
                        r_lcnt    <= '0;
                        r_n_words <= '0;
                        r_n_bits  <= '0;
                        r_err[1]  <= 1'b0;
                        r_biw     <= '0;
                        r_sr      <= '0;
                    end
                end
                ST_HIGH: begin
                    r_lcnt <= w_lcnt_inc;
                    if (w_long) begin
                        r_err[0] <= 1'b1;
                        r_biw    <= '0;
                        r_sr     <= '0;
                        r_lcnt   <= '0;
                    end else if (w_fall) begin
                        if (w_bit_ok) begin
                            r_sr   <= {r_sr[WORD_W-2:0], w_bit_val};
                            r_biw  <= r_biw + 5'd1;
                            r_lcnt <= LCNT_ONE;
                            if (r_biw == 5'd31) begin
                                r_store_pend <= 1'b1;
                            end
                            if (r_n_bits != '1) begin
                                r_n_bits <= r_n_bits + NB_ONE;
                            end
                        end
                    end else begin
                        r_hcnt <= w_hcnt_inc;
                    end
                end
                ST_LOW: begin
                    r_lcnt <= w_lcnt_inc;
                    if (w_rise) begin
                        r_hcnt <= HCNT_ONE;
                    end
                end
                ST_DONE: begin
                    if (w_flush) begin
                        r_err[1] <= 1'b1;
                        r_biw    <= '0;
                    end
                end
                default: begin
                    r_lcnt <= '0;
                end
            endcase
            if (w_we_req) begin
                if (w_has_room) begin
                    r_n_words <= r_n_words + NW_ONE;
                end else begin
                    r_err[2] <= 1'b1;
                end
            end
        end
    end

    sk6812_rx_ram #(
        .ADDR_W (ram_addwidth)
    ) u_ram (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_we    (w_ram_we),
        .i_wa    (r_n_words[ram_addwidth-1:0]),
        .i_wd    (w_wdata),
        .i_ra    (rd_add),
        .o_rd    (rd)
    );

    assign n_words    = r_n_words;
    assign n_bits     = r_n_bits;
    assign err        = r_err;
    assign frame_done = (r_state == ST_DONE);
    assign busy       = (r_state == ST_HIGH) || (r_state == ST_LOW);

endmodule

// File: tb/tb_sk6812_rx.sv
// Self-checking bench for sk6812_rx: randomized bit timing, reference model
// built from the list of bits sent per frame.
module tb_sk6812_rx;

    logic        clk = 1'b0;
    logic        reset, din, enable, clr;
    logic [5:0]  rd_add;
    logic [4:0]  rd_add5;
    logic [31:0] rd, rd5;
    logic [6:0]  n_words;
    logic [5:0]  n_words5;
    logic [10:0] n_bits, n_bits5;
    logic        frame_done, frame_done5, busy, busy5;
    logic [2:0]  err, err5;

    int n_checks = 0;
    int n_pass   = 0;
    int fd_cnt   = 0;
    int fd5_cnt  = 0;
    bit q_bits[$];

    sk6812_rx u_dut (
        .clk(clk), .reset(reset), .din(din), .enable(enable), .clr(clr),
        .rd_add(rd_add), .rd(rd), .n_words(n_words), .n_bits(n_bits),
        .frame_done(frame_done), .busy(busy), .err(err)
    );

    sk6812_rx #(.ram_addwidth(5)) u_dut5 (
        .clk(clk), .reset(reset), .din(din), .enable(enable), .clr(clr),
        .rd_add(rd_add5), .rd(rd5), .n_words(n_words5), .n_bits(n_bits5),
        .frame_done(frame_done5), .busy(busy5), .err(err5)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done)  fd_cnt++;
        if (frame_done5) fd5_cnt++;
    end

    initial begin
        #(20 * 150000);
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic cyc(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic v, input int unsigned n);
        din = v;
        cyc(n);
    endtask

    task automatic send_bit(input bit b, input int unsigned h, input int unsigned l);
        drive(1'b1, h);
        drive(1'b0, l);
        q_bits.push_back(b);
    endtask

    task automatic send_rbit(input bit b);
        send_bit(b, b ? $urandom_range(28, 24) : $urandom_range(10, 6), $urandom_range(8, 5));
    endtask

    task automatic send_word(input logic [31:0] w, input bit nominal);
        for (int unsigned i = 0; i < 32; i++) begin
            if (nominal) send_bit(w[31-i], w[31-i] ? 30 : 15, w[31-i] ? 30 : 45);
            else         send_rbit(w[31-i]);
        end
    endtask

    // Expected buffer word idx: bits idx*32.. of the frame, MSB first, zero-padded.
    function automatic logic [31:0] model_word(input int unsigned idx);
        logic [31:0] w = '0;
        for (int unsigned k = 0; k < 32; k++) begin
            int unsigned p = idx * 32 + k;
            w = {w[30:0], (p < q_bits.size()) ? q_bits[p] : 1'b0};
        end
        return w;
    endfunction

    task automatic read5(input int unsigned a, output logic [31:0] v);
        rd_add5 = a[4:0];
        cyc(1);
        v = rd5;
    endtask

    task automatic read64(input int unsigned a, output logic [31:0] v);
        rd_add = a[5:0];
        cyc(1);
        v = rd;
    endtask

    // Compare the default-depth instance against the model for the frame just sent.
    task automatic check_frame(input string tag, input bit e0, input int fd0);
        int unsigned nb, nw, nwx;
        logic [31:0] v;
        nb  = q_bits.size();
        nw  = (nb + 31) / 32;
        nwx = (nw > 64) ? 64 : nw;
        check_val({tag, "_frame_done"}, fd_cnt - fd0, 1);
        check_val({tag, "_n_words"}, n_words, nwx);
        check_val({tag, "_n_bits"}, n_bits, (nb > 2047) ? 2047 : nb);
        check_val({tag, "_err"}, err, {29'd0, nw > 64, (nb % 32) != 0, e0});
        check_val({tag, "_busy"}, busy, 0);
        for (int unsigned i = 0; i < nwx; i++) begin
            read64(i, v);
            check_val($sformatf("%s_word%0d", tag, i), v, model_word(i));
        end
    endtask

    initial begin
        int fd0, fd50;
        int unsigned nw, extra, g;
        logic [31:0] v, w;

        reset = 1'b0; din = 1'b0; enable = 1'b1; clr = 1'b0;
        rd_add = '0; rd_add5 = '0;
        cyc(5);
        check_val("reset_outs", {rd, n_words, n_bits, frame_done, busy, err},
                  {32'd0, 7'd0, 11'd0, 1'b0, 1'b0, 3'd0});
        reset = 1'b1;

        // Nominal timing, single word.
        drive(1'b0, 2600);
        fd0 = fd_cnt; q_bits.delete();
        send_word(32'hA5C30F81, 1'b1);
        drive(1'b0, 2700);
        check_frame("t1", 1'b0, fd0);
        read64(0, v);
        check_val("t1_const_word", v, 32'hA5C30F81);

        // Short high glitch inside one low period must not disturb the word.
        fd0 = fd_cnt; q_bits.delete();
        w = 32'hFFFF0000;
        g = $urandom_range(30, 0);
        for (int unsigned i = 0; i < 32; i++) begin
            if (i == g) begin
                drive(1'b1, w[31-i] ? 26 : 8);
                drive(1'b0, 6); drive(1'b1, 3); drive(1'b0, 8);
                q_bits.push_back(w[31-i]);
            end else begin
                send_rbit(w[31-i]);
            end
        end
        drive(1'b0, 2700);
        check_frame("t3", 1'b0, fd0);

        // 40 bits: one full word and a left-justified partial word.
        fd0 = fd_cnt; q_bits.delete();
        send_word(32'h12345678, 1'b0);
        for (int unsigned i = 0; i < 8; i++) send_rbit(v[0] ^ v[0] ^ ((8'hAB >> (7 - i)) & 1));
        drive(1'b0, 2700);
        check_frame("t5", 1'b0, fd0);
        read64(1, v);
        check_val("t5_partial", v, 32'hAB000000);

        // Random frames with a partial tail.
        for (int unsigned it = 0; it < 2; it++) begin
            fd0 = fd_cnt; q_bits.delete();
            nw = $urandom_range(3, 1);
            extra = $urandom_range(31, 1);
            for (int unsigned k = 0; k < nw; k++) send_word($urandom, 1'b0);
            for (int unsigned k = 0; k < extra; k++) send_rbit($urandom_range(1, 0));
            drive(1'b0, 2700);
            check_frame($sformatf("rnd%0d", it), 1'b0, fd0);
        end

        // 36 words: overflow on the 32-deep instance, fits in the 64-deep one.
        fd0 = fd_cnt; fd50 = fd5_cnt; q_bits.delete();
        for (int unsigned k = 0; k < 36; k++) send_word($urandom, 1'b0);
        drive(1'b0, 2700);
        check_val("t2_fd5", fd5_cnt - fd50, 1);
        check_val("t2_nw5", n_words5, 32);
        check_val("t2_err5", err5, 3'b100);
        check_val("t2_nbits5", n_bits5, 36 * 32);
        for (int unsigned i = 0; i < 32; i++) begin
            read5(i, v);
            check_val($sformatf("t2_word5_%0d", i), v, model_word(i));
        end
        check_frame("t2", 1'b0, fd0);

        // clr clears counts and sticky errors.
        clr = 1'b1; cyc(1); clr = 1'b0;
        check_val("clr_err5", err5, 0);
        check_val("clr_nw5", n_words5, 0);
        check_val("clr_nw", n_words, 0);
        check_val("clr_nbits", n_bits, 0);

        // Over-long high mid-word: error, resync, later frame still decodes.
        drive(1'b0, 2600);
        q_bits.delete();
        for (int unsigned k = 0; k < 10; k++) send_rbit($urandom_range(1, 0));
        check_val("t4_busy_mid", busy, 1);
        drive(1'b1, 100);
        check_val("t4_err", err, 3'b001);
        check_val("t4_busy", busy, 0);
        fd0 = fd_cnt;
        for (int unsigned k = 0; k < 8; k++) send_rbit($urandom_range(1, 0));
        drive(1'b0, 2700);
        check_val("t4_no_done", fd_cnt - fd0, 0);
        fd0 = fd_cnt; q_bits.delete();
        send_word($urandom, 1'b0);
        drive(1'b0, 2700);
        check_frame("t4", 1'b1, fd0);

        // Reset mid-word, then a word with no leading gap is ignored.
        for (int unsigned k = 0; k < 12; k++) send_rbit($urandom_range(1, 0));
        reset = 1'b0;
        #1;
        check_val("t6_reset_outs", {rd, n_words, n_bits, frame_done, busy, err},
                  {32'd0, 7'd0, 11'd0, 1'b0, 1'b0, 3'd0});
        cyc(3);
        reset = 1'b1;
        fd0 = fd_cnt;
        send_word($urandom, 1'b0);
        drive(1'b0, 2700);
        check_val("t6_no_done", fd_cnt - fd0, 0);
        check_val("t6_nbits", n_bits, 0);
        check_val("t6_nwords", n_words, 0);
        fd0 = fd_cnt; q_bits.delete();
        send_word($urandom, 1'b0);
        drive(1'b0, 2700);
        check_frame("t6", 1'b0, fd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
